// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the 32x32 register file: arbitrates requesters onto A3/WD3/WE3
// and keeps the busy scoreboard that stalls issue. Define WB_RR_ARB_EN for round-robin arbitration.
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int RA_W    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*RA_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_wd,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    iss_valid,
    input  logic [RA_W-1:0]         iss_rs1,
    input  logic [RA_W-1:0]         iss_rs2,
    input  logic [RA_W-1:0]         iss_rd,
    output logic                    iss_stall,
    output logic [RA_W-1:0]         A3,
    output logic [XLEN-1:0]         WD3,
    output logic                    WE3,
    output logic [2**RA_W-1:0]      busy
);

    localparam int NREG = 2**RA_W;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any;
    logic               w_accept;
    logic [RA_W-1:0]    w_sel_rd;
    logic [XLEN-1:0]    w_sel_wd;
    logic               w_issue;
    logic [NREG-1:0]    w_busy_nxt;
    logic [NREG-1:0]    r_busy;

`ifdef WB_RR_ARB_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    int               w_dist;
    int               w_best;

    // Winner is the valid requester at the smallest circular distance from the pointer.
    always_comb begin
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + NUM_REQ - int'(r_ptr));
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_gnt     = '0;
                w_gnt[i]  = 1'b1;
                w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    always_comb begin
        w_gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_gnt    = '0;
                w_gnt[i] = 1'b1;
            end
        end
    end
`endif

    assign w_any     = |w_gnt;
    assign w_accept  = reset & w_any;
    assign req_ready = reset ? w_gnt : '0;

    always_comb begin
        w_sel_rd = '0;
        w_sel_wd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd = req_rd[i*RA_W +: RA_W];
                w_sel_wd = req_wd[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            A3  <= '0;
            WD3 <= '0;
            WE3 <= 1'b0;
        end else if (w_accept) begin
            A3  <= w_sel_rd;
            WD3 <= w_sel_wd;
            WE3 <= (w_sel_rd != '0);
        end else begin
            WE3 <= 1'b0;
        end
    end

    assign iss_stall = ~reset | (iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd]));
    assign w_issue   = iss_valid & ~iss_stall & (iss_rd != '0);

    // Set is applied after clear so a new producer keeps ownership on a same-edge collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (WE3) begin
            w_busy_nxt[A3] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed test-plan sequences plus random traffic
// checked against a queue/array reference model.
module tb_regfile_wb_scheduler;

    localparam int N = 2;
`ifdef WB_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [9:0]    req_rd;
    logic [63:0]   req_wd;
    logic [1:0]    req_ready;
    logic          iss_valid;
    logic [4:0]    iss_rs1;
    logic [4:0]    iss_rs2;
    logic [4:0]    iss_rd;
    logic          iss_stall;
    logic [4:0]    A3;
    logic [31:0]   WD3;
    logic          WE3;
    logic [31:0]   busy;

    regfile_wb_scheduler #(.NUM_REQ(2), .XLEN(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_stall(iss_stall),
        .A3(A3), .WD3(WD3), .WE3(WE3), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic [31:0] m_busy = '0;
    int          m_ptr  = 0;
    bit          m_pend = 1'b0;
    logic [4:0]  m_pend_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, compare combinational/scoreboard outputs, advance model.
    task automatic step(input bit rst_n, input logic [1:0] v, input logic [9:0] rd,
                        input logic [63:0] wd, input bit iv, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] ird, output int gnt);
        logic [1:0] e_ready;
        bit         e_stall;
        int         idx;
        wr_t        w;
        @(negedge clk);
        reset     = rst_n;
        req_valid = v;
        req_rd    = rd;
        req_wd    = wd;
        iss_valid = iv;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = ird;
        #1;
        gnt = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                idx = RR ? ((m_ptr + k) % N) : k;
                if (gnt < 0 && v[idx]) gnt = idx;
            end
        end
        e_ready = (gnt >= 0) ? 2'(1 << gnt) : 2'b00;
        e_stall = !rst_n || (iv && (m_busy[rs1] || m_busy[rs2] || m_busy[ird]));
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("iss_stall", 64'(iss_stall), 64'(e_stall));
        chk("busy", 64'(busy), 64'(m_busy));
        if (!rst_n) begin
            m_busy = '0;
            m_ptr  = 0;
            m_pend = 1'b0;
            exp_q.delete();
        end else begin
            if (m_pend) m_busy[m_pend_rd] = 1'b0;
            if (iv && !e_stall && ird != 5'd0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
            m_pend = 1'b0;
            if (gnt >= 0) begin
                w.rd = rd[gnt*5 +: 5];
                w.wd = wd[gnt*32 +: 32];
                if (w.rd != 5'd0) begin
                    exp_q.push_back(w);
                    m_pend    = 1'b1;
                    m_pend_rd = w.rd;
                end
                m_ptr = (gnt + 1) % N;
            end
        end
    endtask

    task automatic monitor();
        wr_t e;
        bit  exp_we;
        forever begin
            @(posedge clk);
            #1;
            exp_we = (exp_q.size() > 0);
            chk("WE3", 64'(WE3), 64'(exp_we));
            if (exp_we) begin
                e = exp_q.pop_front();
                if (WE3 === 1'b1) begin
                    chk("A3", 64'(A3), 64'(e.rd));
                    chk("WD3", 64'(WD3), 64'(e.wd));
                end
            end
        end
    endtask

    logic [1:0] ctab [4];
    logic [1:0] rv;
    logic [9:0] rrd;
    logic [63:0] rwd;
    bit         hold [2];
    bit         iv;
    logic [4:0] rs1, rs2, ird;
    int         g;

    initial begin
        reset = 1'b0; req_valid = '0; req_rd = '0; req_wd = '0;
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        if (RR) ctab = '{2'b01, 2'b10, 2'b01, 2'b10};
        else    ctab = '{2'b01, 2'b01, 2'b01, 2'b01};

        // Reset held two cycles with both requesters asking
        step(0, 2'b11, {5'd2, 5'd1}, {32'h22, 32'h11}, 0, 5'd0, 5'd0, 5'd0, g);
        step(0, 2'b11, {5'd2, 5'd1}, {32'h22, 32'h11}, 0, 5'd0, 5'd0, 5'd0, g);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_stall", 64'(iss_stall), 64'd1);
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        fork monitor(); join_none
        step(1, 2'b11, {5'd2, 5'd1}, {32'h22, 32'h11}, 0, 5'd0, 5'd0, 5'd0, g);
        chk("release_ready", 64'(req_ready), 64'd1);
        step(1, 2'b10, {5'd3, 5'd0}, {32'h33, 32'h0}, 0, 5'd0, 5'd0, 5'd0, g);

        // Contention: both valid four cycles
        for (int c = 0; c < 4; c++) begin
            step(1, 2'b11, {5'd2, 5'd1}, {32'hB0 + 32'(c), 32'hA0 + 32'(c)}, 0, 5'd0, 5'd0, 5'd0, g);
            chk($sformatf("contend_gnt%0d", c), 64'(req_ready), 64'(ctab[c]));
        end

        // Single write; the monitor checks A3/WD3/WE3 the following cycles
        step(1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 0, 5'd0, 5'd0, 5'd0, g);
        step(1, 2'b00, '0, '0, 0, 5'd0, 5'd0, 5'd0, g);
        chk("single_we3", 64'(WE3), 64'd1);
        chk("single_wd3", 64'(WD3), 64'hDEADBEEF);
        step(1, 2'b00, '0, '0, 0, 5'd0, 5'd0, 5'd0, g);
        chk("single_we3_off", 64'(WE3), 64'd0);

        // x0 write completes the handshake without a write enable
        step(1, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 0, 5'd0, 5'd0, 5'd0, g);
        chk("x0_ready", 64'(req_ready), 64'd1);
        step(1, 2'b00, '0, '0, 0, 5'd0, 5'd0, 5'd0, g);
        chk("x0_we3", 64'(WE3), 64'd0);

        // RAW hazard on x7
        step(1, 2'b00, '0, '0, 1, 5'd0, 5'd0, 5'd7, g);
        step(1, 2'b00, '0, '0, 1, 5'd7, 5'd0, 5'd0, g);
        chk("raw_busy7", 64'(busy[7]), 64'd1);
        chk("raw_stall_a", 64'(iss_stall), 64'd1);
        step(1, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 1, 5'd7, 5'd0, 5'd0, g);
        chk("raw_stall_b", 64'(iss_stall), 64'd1);
        step(1, 2'b00, '0, '0, 1, 5'd7, 5'd0, 5'd0, g);
        chk("raw_stall_we", 64'(iss_stall), 64'd1);
        step(1, 2'b00, '0, '0, 1, 5'd7, 5'd0, 5'd0, g);
        chk("raw_stall_drop", 64'(iss_stall), 64'd0);

        // Set/clear collision on x9: set wins
        step(1, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 0, 5'd0, 5'd0, 5'd0, g);
        step(1, 2'b00, '0, '0, 1, 5'd0, 5'd0, 5'd9, g);
        chk("coll_we3", 64'(WE3), 64'd1);
        step(1, 2'b00, '0, '0, 0, 5'd0, 5'd0, 5'd0, g);
        chk("coll_busy9", 64'(busy[9]), 64'd1);
        step(1, 2'b10, {5'd9, 5'd0}, {32'h9A, 32'h0}, 0, 5'd0, 5'd0, 5'd0, g);

        // Random traffic with a reset in the middle
        hold = '{1'b0, 1'b0};
        rv = '0; rrd = '0; rwd = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                step(0, 2'b11, rrd, rwd, 1, 5'd1, 5'd2, 5'd3, g);
                hold = '{1'b0, 1'b0};
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!hold[i]) begin
                        rv[i] = ($urandom_range(0, 3) != 0);
                        rrd[i*5 +: 5] = 5'($urandom_range(0, 7));
                        rwd[i*32 +: 32] = $urandom;
                    end
                end
                iv  = ($urandom_range(0, 1) == 1);
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                ird = 5'($urandom_range(0, 7));
                step(1, rv, rrd, rwd, iv, rs1, rs2, ird, g);
                for (int i = 0; i < N; i++) hold[i] = rv[i] && (g != i);
            end
        end

        for (int c = 0; c < 4; c++) step(1, 2'b00, '0, '0, 0, 5'd0, 5'd0, 5'd0, g);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences all writes into the 32x32 register file and tracks register hazards.
- Arbitrates NUM_REQ write-back requesters (ALU, LSU, ...) onto the single write port (A3/WD3/WE3), using valid/ready handshakes.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards.
- Sits between the execute/memory write-back paths and the register file write port.

Parameters:
- NUM_REQ, 2, number of write-back requesters; index 0 is highest priority after reset.
- XLEN, 32, data width.
- RA_W, 5, register address width; 2**RA_W registers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  write-back request per requester.
- req_rd  input  NUM_REQ*RA_W  packed destination register; requester i uses bits [i*RA_W +: RA_W].
- req_wd  input  NUM_REQ*XLEN  packed write data; requester i uses bits [i*XLEN +: XLEN].
- req_ready  output  NUM_REQ  grant; at most one bit high; transfer when valid&ready.
- iss_valid  input  1  issue stage presents an instruction.
- iss_rs1  input  RA_W  first source register.
- iss_rs2  input  RA_W  second source register.
- iss_rd  input  RA_W  destination register; 0 means no destination.
- iss_stall  output  1  combinational; issue must hold.
- A3  output  RA_W  register file write address (registered).
- WD3  output  XLEN  register file write data (registered).
- WE3  output  1  register file write enable (registered).
- busy  output  2**RA_W  scoreboard; bit 0 is constant 0.

Behaviour:
- Reset (reset==0 at a rising edge):
  - A3=0, WD3=0, WE3=0, busy=0; round-robin pointer=0.
  - While reset is low, req_ready=0 and iss_stall=1 combinationally.
  - Reset mid-operation drops any pending WE3 and clears all busy bits.
- Arbitration:
  - Combinational; one grant per cycle whenever any req_valid is high; no grant when none is valid.
  - The register file never back-pressures, so a valid requester is refused only by losing arbitration.
  - Round-robin: search starts at pointer and wraps NUM_REQ-1 -> 0. On a grant to i, pointer <= (i+1) mod NUM_REQ; with no grant the pointer holds.
- Write path (latency 1):
  - On an accepted transfer in cycle T: A3<=rd, WD3<=wd, WE3<=(rd!=0) at edge T.
  - The register file commits at edge T+1.
  - With no accept in T: WE3<=0; A3 and WD3 hold.
  - An accepted write to x0 completes the handshake but produces WE3=0.
- Scoreboard:
  - Set busy[iss_rd] at the edge when iss_valid & !iss_stall & iss_rd!=0.
  - Clear busy[A3] at the edge when WE3==1, i.e. the same edge the register file commits. An instruction issued the following cycle therefore reads the committed value.
  - Set and clear of the same register at the same edge: set wins, because the newer producer owns the register.
  - Write-back to a non-busy register is legal; the scoreboard stays unchanged apart from the clear rule.
- Stall:
  - iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]).
  - Index 0 is never busy, so x0 never stalls.
  - iss_stall=0 when iss_valid=0 (except during reset).
- Requesters must hold rd and wd stable while valid and not ready.

Optional Feature:
- Macro: WB_RR_ARB_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, lowest index wins every cycle; pointer logic is removed.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with req_valid=2'b11 -> req_ready=0, iss_stall=1, WE3=0, busy=0. Release -> req_ready=2'b01 in the next cycle.
2. Single write: req 0 valid, rd=5, wd=0xDEADBEEF in cycle T -> A3=5, WD3=0xDEADBEEF, WE3=1 during T+1; WE3=0 in T+2.
3. Contention: both requesters valid for 4 cycles (rd=1 and rd=2).
   - Round-robin build: grants 0,1,0,1.
   - Fixed-priority build: grants 0,0,0,0.
4. x0 write: accept rd=0, wd=0x1234 -> req_ready=1 and WE3 stays 0.
5. RAW hazard: issue rd=7 -> busy[7]=1. Issue rs1=7 -> iss_stall=1 until the write-back for rd=7 has WE3=1; stall drops in the cycle after that edge.
6. Collision: issue rd=9 at the same edge where WE3=1 with A3=9 -> busy[9] remains 1.
